gat_bram_load_ctrl: RTL and testbench
=====================================

# gat_bram_load_ctrl

Parametrised host-to-BRAM load controller that sits between the block-design register/BRAM interface and `gat_top`. It takes one 32-bit, byte-addressed host write stream with a channel select and converts it to word-addressed, width-truncated writes on NUM_CH downstream BRAM ports. It counts words per channel against runtime-programmed expected counts and raises per-channel load-done flags, then a single start pulse. It replaces hand-driven `*_load_done` inputs and adds protocol error detection.

## Interface
Parameters:
- TOP_WIDTH, 32, host data width
- NUM_CH, 4, number of downstream BRAM channels (h_data, h_node_info, wgt, subgraph)
- DATA_W, 20, downstream data width; host_din[DATA_W-1:0] forwarded, upper bits discarded
- ADDR_W, 18, downstream word-address width
- CNT_W, ADDR_W+1, expected-count width
- CH_W, $clog2(NUM_CH) (min 1), channel-select width

Ports (one clock; synchronous active-low reset, fixed):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cfg_start  in  1  pulse: clear counters/flags, arm loading
- cfg_exp_cnt  in  NUM_CH*CNT_W  expected word count, channel c at [c*CNT_W +: CNT_W]; sampled on cfg_start
- host_valid  in  1  write request
- host_ready  out  1  write accepted when valid & ready
- host_ch_sel  in  CH_W  target channel
- host_addra  in  ADDR_W+2  byte address
- host_din  in  TOP_WIDTH  write data
- bram_ena  out  NUM_CH  one-hot enable
- bram_wea  out  NUM_CH  one-hot write enable, equal to bram_ena
- bram_addra  out  ADDR_W  word address (host_addra[ADDR_W+1:2])
- bram_din  out  DATA_W  truncated data
- load_done  out  NUM_CH  per-channel done flags
- gat_start  out  1  one-cycle pulse, all channels done
- busy  out  1  state==LOAD
- err_code  out  3  0 none, 1 bad channel, 2 misaligned address, 3 address >= expected count, 4 write to done channel

## Operation
- States: IDLE, LOAD, DONE, ERR.
- IDLE -> LOAD on cfg_start. LOAD/DONE/ERR -> LOAD on cfg_start (restart). Counters, load_done, err_code clear; exp counts latched.
- host_ready = (state==LOAD) & ~cfg_start. Writes are never accepted in IDLE, DONE or ERR.
- An accepted write is checked in priority order 1,2,3,4 (codes above). On any error: no BRAM write, no count change, err_code latched, state -> ERR. Otherwise: write forwarded, cnt[ch]++.
- load_done[c] sets when cnt[c]==exp[c]. Channels with exp==0 are done immediately on arming.
- When all load_done bits are 1 in LOAD: gat_start pulses, state -> DONE.
- Address uniqueness is not checked. Completion is by write count only.

## Timing
- Reset: state IDLE; host_ready, bram_ena, bram_wea, bram_addra, bram_din, load_done, gat_start, busy and err_code all 0; counters 0.
- Write accepted at cycle N -> bram_ena/wea/addra/din valid at N+1 for exactly one cycle (registered).
- load_done[c] asserts at N+1 for the completing write, together with that write's BRAM strobe.
- gat_start pulses at N+2; state is DONE at N+2.
- Arming with cfg_start at cycle M: exp==0 channels show load_done at M+1. If all exp==0, gat_start pulses at M+2.
- err_code and ERR are visible at N+1 and held until the next cfg_start.
- Back-to-back accepts are allowed every cycle in LOAD (throughput 1 word/cycle).
- cfg_start concurrent with host_valid: the write is not accepted, and the restart takes effect.
- rst_n low at any point: immediate return to reset values on the next edge. Any write in flight is dropped.

## Structure
- Shared package `gat_pkg`: state enum (IDLE/LOAD/DONE/ERR), err_code constants (ERR_NONE..ERR_DONE_CH).
- Sub-module `gat_load_ch_cnt` (instantiated NUM_CH times): holds the latched exp count and the counter; provides done and addr_oob outputs; has clear, load and inc inputs.
- The top level holds the FSM, error priority logic, the output register stage and the gat_start pulse.

## Test plan
- Arm with exp={4,2,3,1}. Write to ch0 addr 0,4,8,12, then ch1 0,4, ch2 0,4,8, ch3 0 -> each write is seen one cycle later with the correct one-hot ena and word addrs 0..3. gat_start is a single pulse 2 cycles after the last accept.
- host_din=0xFFFF_ABCD with DATA_W=20 -> bram_din=0xFABCD.
- Misaligned write addr 0x6 -> no BRAM write, err_code=2, host_ready=0. Then cfg_start -> err_code=0, busy=1.
- ch_sel=5 with NUM_CH=4 -> err_code=1. A write to ch1 after it is done (exp=2, third write) -> err_code=4. Addr 0x10 with exp=4 -> err_code=3.
- Arm with all exp=0 -> load_done=4'hF at M+1, gat_start at M+2.
- cfg_start asserted together with host_valid mid-load -> the write is dropped and counters are zero. rst_n low mid-load -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/gat_pkg.sv
// Shared types for the GAT BRAM load path: load FSM states and error codes
// reported on err_code.
package gat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } load_state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BAD_CH   = 3'd1;
  localparam logic [2:0] ERR_MISALIGN = 3'd2;
  localparam logic [2:0] ERR_OOB      = 3'd3;
  localparam logic [2:0] ERR_DONE_CH  = 3'd4;

endpackage

// File: rtl/gat_load_ch_cnt.sv
// Per-channel word counter: latches the expected count on arming and reports
// completion plus whether an incoming word address lies past the expected count.
module gat_load_ch_cnt #(
  parameter int ADDR_W = 18,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              inc,
  input  logic [CNT_W-1:0]  exp_in,
  input  logic [ADDR_W-1:0] word_addr,
  output logic              done,
  output logic              addr_oob
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] exp_r;
  logic [CNT_W-1:0] cnt_r;
  logic             done_r;

  // Expected count, write counter and done flag; a zero expectation is done on arming.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_r  <= CNT_ZERO;
      cnt_r  <= CNT_ZERO;
      done_r <= 1'b0;
    end else begin
      if (clear) begin
        cnt_r <= CNT_ZERO;
      end else if (inc) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      if (load) begin
        exp_r <= exp_in;
      end
      if (load) begin
        done_r <= (exp_in == CNT_ZERO);
      end else if (clear) begin
        done_r <= 1'b0;
      end else if (inc) begin
        done_r <= ((cnt_r + CNT_ONE) == exp_r);
      end
    end
  end

  assign done     = done_r;
  assign addr_oob = (CNT_W'(word_addr) >= exp_r);

endmodule

// File: rtl/gat_bram_load_ctrl.sv
// Host-to-BRAM load controller: routes a byte-addressed host write stream to
// NUM_CH word-addressed BRAM ports, tracks per-channel completion, flags errors.
module gat_bram_load_ctrl
  import gat_pkg::*;
#(
  parameter int TOP_WIDTH = 32,
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 20,
  parameter int ADDR_W    = 18,
  parameter int CNT_W     = ADDR_W + 1,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic [NUM_CH*CNT_W-1:0] cfg_exp_cnt,
  input  logic                    host_valid,
  output logic                    host_ready,
  input  logic [CH_W-1:0]         host_ch_sel,
  input  logic [ADDR_W+1:0]       host_addra,
  input  logic [TOP_WIDTH-1:0]    host_din,
  output logic [NUM_CH-1:0]       bram_ena,
  output logic [NUM_CH-1:0]       bram_wea,
  output logic [ADDR_W-1:0]       bram_addra,
  output logic [DATA_W-1:0]       bram_din,
  output logic [NUM_CH-1:0]       load_done,
  output logic                    gat_start,
  output logic                    busy,
  output logic [2:0]              err_code
);

  localparam logic [NUM_CH-1:0] CH_ZERO = {NUM_CH{1'b0}};

  load_state_t       state_r;
  logic              busy_r;
  logic              gat_start_r;
  logic [2:0]        err_r;
  logic [NUM_CH-1:0] ena_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] din_r;

  logic              accept_s;
  logic [2:0]        chk_s;
  logic [NUM_CH-1:0] sel_s;
  logic [NUM_CH-1:0] done_s;
  logic [NUM_CH-1:0] oob_s;
  logic [NUM_CH-1:0] inc_s;
  logic [ADDR_W-1:0] word_addr_s;

  assign word_addr_s = host_addra[ADDR_W+1:2];
  assign host_ready  = busy_r & ~cfg_start;
  assign accept_s    = host_valid & host_ready;

  // One-hot channel decode; an out-of-range select decodes to all zeros.
  always_comb begin
    sel_s = CH_ZERO;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_s[c] = (host_ch_sel == CH_W'(c));
    end
  end

  // Write checks in priority order: channel, alignment, range, already-done.
  always_comb begin
    chk_s = ERR_NONE;
    if (sel_s == CH_ZERO) begin
      chk_s = ERR_BAD_CH;
    end else if (host_addra[1:0] != 2'b00) begin
      chk_s = ERR_MISALIGN;
    end else if ((oob_s & sel_s) != CH_ZERO) begin
      chk_s = ERR_OOB;
    end else if ((done_s & sel_s) != CH_ZERO) begin
      chk_s = ERR_DONE_CH;
    end else begin
      chk_s = ERR_NONE;
    end
  end

  assign inc_s = (accept_s && (chk_s == ERR_NONE)) ? sel_s : CH_ZERO;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gat_load_ch_cnt #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (cfg_start),
      .load      (cfg_start),
      .inc       (inc_s[c]),
      .exp_in    (cfg_exp_cnt[c*CNT_W +: CNT_W]),
      .word_addr (word_addr_s),
      .done      (done_s[c]),
      .addr_oob  (oob_s[c])
    );
  end

  if (TOP_WIDTH > DATA_W) begin : g_din_trunc
    logic unused_din_s;
    assign unused_din_s = ^host_din[TOP_WIDTH-1:DATA_W];
  end

  // Load FSM with registered BRAM strobe, start pulse and sticky error code.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      gat_start_r <= 1'b0;
      err_r       <= ERR_NONE;
      ena_r       <= CH_ZERO;
      addr_r      <= {ADDR_W{1'b0}};
      din_r       <= {DATA_W{1'b0}};
    end else begin
      gat_start_r <= 1'b0;
      ena_r       <= CH_ZERO;
      addr_r      <= {ADDR_W{1'b0}};
      din_r       <= {DATA_W{1'b0}};
      if (cfg_start) begin
        state_r <= ST_LOAD;
        busy_r  <= 1'b1;
        err_r   <= ERR_NONE;
      end else begin
        case (state_r)
          ST_LOAD: begin
            if (accept_s && (chk_s != ERR_NONE)) begin
              state_r <= ST_ERR;
              busy_r  <= 1'b0;
              err_r   <= chk_s;
            end else if (accept_s) begin
              ena_r  <= sel_s;
              addr_r <= word_addr_s;
              din_r  <= host_din[DATA_W-1:0];
            end else if (&done_s) begin
              gat_start_r <= 1'b1;
              state_r     <= ST_DONE;
              busy_r      <= 1'b0;
            end
          end
          ST_IDLE, ST_DONE, ST_ERR: begin
            state_r <= state_r;
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bram_ena   = ena_r;
  assign bram_wea   = ena_r;
  assign bram_addra = addr_r;
  assign bram_din   = din_r;
  assign load_done  = done_s;
  assign gat_start  = gat_start_r;
  assign busy       = busy_r;
  assign err_code   = err_r;

endmodule

// File: tb/tb_gat_bram_load_ctrl.sv
// Randomized self-checking bench for gat_bram_load_ctrl against a per-cycle
// behavioural model, plus directed literal checks from the load scenarios.
module tb_gat_bram_load_ctrl;

  localparam int NUM_CH    = 4;
  localparam int ADDR_W    = 18;
  localparam int CNT_W     = ADDR_W + 1;
  localparam int DATA_W    = 20;
  localparam int TOP_WIDTH = 32;
  localparam int CH_W      = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n;
  logic                    cfg_start;
  logic [NUM_CH*CNT_W-1:0] cfg_exp_cnt;
  logic                    host_valid;
  logic                    host_ready;
  logic [CH_W-1:0]         host_ch_sel;
  logic [ADDR_W+1:0]       host_addra;
  logic [TOP_WIDTH-1:0]    host_din;
  logic [NUM_CH-1:0]       bram_ena;
  logic [NUM_CH-1:0]       bram_wea;
  logic [ADDR_W-1:0]       bram_addra;
  logic [DATA_W-1:0]       bram_din;
  logic [NUM_CH-1:0]       load_done;
  logic                    gat_start;
  logic                    busy;
  logic [2:0]              err_code;

  // three-channel instance: select value 3 is an invalid channel there
  logic                    d3_ready;
  logic [2:0]              d3_ena;
  logic [2:0]              d3_wea;
  logic [ADDR_W-1:0]       d3_addra;
  logic [DATA_W-1:0]       d3_din;
  logic [2:0]              d3_load_done;
  logic                    d3_gat_start;
  logic                    d3_busy;
  logic [2:0]              d3_err_code;

  gat_bram_load_ctrl #(
    .TOP_WIDTH(TOP_WIDTH), .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_exp_cnt(cfg_exp_cnt),
    .host_valid(host_valid), .host_ready(host_ready), .host_ch_sel(host_ch_sel),
    .host_addra(host_addra), .host_din(host_din), .bram_ena(bram_ena),
    .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_din(bram_din),
    .load_done(load_done), .gat_start(gat_start), .busy(busy), .err_code(err_code)
  );

  gat_bram_load_ctrl #(
    .TOP_WIDTH(TOP_WIDTH), .NUM_CH(3), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_exp_cnt(cfg_exp_cnt[3*CNT_W-1:0]),
    .host_valid(host_valid), .host_ready(d3_ready), .host_ch_sel(host_ch_sel),
    .host_addra(host_addra), .host_din(host_din), .bram_ena(d3_ena),
    .bram_wea(d3_wea), .bram_addra(d3_addra), .bram_din(d3_din),
    .load_done(d3_load_done), .gat_start(d3_gat_start), .busy(d3_busy), .err_code(d3_err_code)
  );

  int n_pass  = 0;
  int n_total = 0;

  // behavioural model of the main instance
  int     m_exp [NUM_CH];
  int     m_cnt [NUM_CH];
  bit     m_armed, m_loading;
  int     m_err, m_gat, m_ena, m_addr;
  longint m_din;

  task automatic check(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
  endtask

  function automatic bit m_done(input int c);
    return m_armed && (m_cnt[c] == m_exp[c]);
  endfunction

  task automatic model_step();
    int ch, code;
    bit all_done;
    m_gat = 0; m_ena = 0; m_addr = 0; m_din = 0;
    all_done = 1'b1;
    for (int c = 0; c < NUM_CH; c++) if (!m_done(c)) all_done = 1'b0;
    if (!rst_n) begin
      m_loading = 0; m_armed = 0; m_err = 0;
      for (int c = 0; c < NUM_CH; c++) begin m_cnt[c] = 0; m_exp[c] = 0; end
    end else if (cfg_start) begin
      m_loading = 1; m_armed = 1; m_err = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_cnt[c] = 0;
        m_exp[c] = int'(cfg_exp_cnt[c*CNT_W +: CNT_W]);
      end
    end else if (m_loading && host_valid) begin
      ch = int'(host_ch_sel);
      code = 0;
      if (ch >= NUM_CH) code = 1;
      else if (host_addra[1:0] != 2'b00) code = 2;
      else if (int'(host_addra >> 2) >= m_exp[ch]) code = 3;
      else if (m_cnt[ch] == m_exp[ch]) code = 4;
      if (code != 0) begin
        m_err = code; m_loading = 0;
      end else begin
        m_ena  = 1 << ch;
        m_addr = int'(host_addra >> 2);
        m_din  = longint'(host_din) & ((64'd1 << DATA_W) - 64'd1);
        m_cnt[ch]++;
      end
    end else if (m_loading && all_done) begin
      m_gat = 1; m_loading = 0;
    end
  endtask

  task automatic compare_all();
    int exp_done;
    exp_done = 0;
    for (int c = 0; c < NUM_CH; c++) if (m_done(c)) exp_done |= (1 << c);
    check("bram_ena",   bram_ena,   m_ena);
    check("bram_wea",   bram_wea,   m_ena);
    check("bram_addra", bram_addra, m_addr);
    check("bram_din",   bram_din,   m_din);
    check("load_done",  load_done,  exp_done);
    check("gat_start",  gat_start,  m_gat);
    check("busy",       busy,       m_loading);
    check("err_code",   err_code,   m_err);
    check("host_ready", host_ready, m_loading && !cfg_start);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic arm(input int e0, input int e1, input int e2, input int e3);
    int e [NUM_CH];
    e = '{e0, e1, e2, e3};
    for (int c = 0; c < NUM_CH; c++) cfg_exp_cnt[c*CNT_W +: CNT_W] = CNT_W'(e[c]);
    cfg_start = 1'b1;
    cycle();
    cfg_start = 1'b0;
  endtask

  task automatic wr(input int ch, input int addr, input logic [31:0] din);
    host_valid  = 1'b1;
    host_ch_sel = CH_W'(ch);
    host_addra  = (ADDR_W+2)'(addr);
    host_din    = din;
    cycle();
    host_valid  = 1'b0;
  endtask

  initial begin
    int r, ch, word, lim;
    rst_n = 1'b0; cfg_start = 1'b0; host_valid = 1'b0;
    cfg_exp_cnt = '0; host_ch_sel = '0; host_addra = '0; host_din = '0;
    repeat (3) cycle();
    check("reset_err", err_code, 3'd0);
    check("reset_done", load_done, 4'h0);
    rst_n = 1'b1;
    cycle();

    // full load: exp = {4,2,3,1}
    arm(4, 2, 3, 1);
    wr(0, 0, 32'hFFFF_ABCD);
    check("din_trunc", bram_din, 20'hFABCD);
    check("d3_ena_ch0", d3_ena, 3'b001);
    wr(0, 4, 32'h1); wr(0, 8, 32'h2); wr(0, 12, 32'h3);
    check("ch0_addr3", bram_addra, 18'd3);
    wr(1, 0, 32'h4); wr(1, 4, 32'h5);
    wr(2, 0, 32'h6); wr(2, 4, 32'h7); wr(2, 8, 32'h8);
    wr(3, 0, 32'h9);
    check("last_ena", bram_ena, 4'b1000);
    check("all_done", load_done, 4'hF);
    check("no_start_yet", gat_start, 1'b0);
    check("d3_err_bad_ch", d3_err_code, 3'd1);
    cycle();
    check("gat_start_pulse", gat_start, 1'b1);
    cycle();
    check("gat_start_single", gat_start, 1'b0);

    // misaligned address, then recovery by re-arming
    arm(4, 2, 3, 1);
    wr(0, 6, 32'h0);
    check("misalign_err", err_code, 3'd2);
    check("misalign_ready", host_ready, 1'b0);
    check("misalign_no_wr", bram_ena, 4'h0);
    arm(4, 2, 3, 1);
    check("rearm_err", err_code, 3'd0);
    check("rearm_busy", busy, 1'b1);

    // write to a completed channel
    wr(1, 0, 32'h0); wr(1, 4, 32'h0); wr(1, 0, 32'h0);
    check("done_ch_err", err_code, 3'd4);

    // address beyond expected count
    arm(4, 2, 3, 1);
    wr(0, 16, 32'h0);
    check("oob_err", err_code, 3'd3);

    // all-zero expectation
    arm(0, 0, 0, 0);
    check("zero_done", load_done, 4'hF);
    check("zero_no_start", gat_start, 1'b0);
    cycle();
    check("zero_start", gat_start, 1'b1);

    // restart collides with a write
    arm(4, 2, 3, 1);
    wr(0, 0, 32'h11);
    host_valid = 1'b1; host_ch_sel = 2'd0; host_addra = 20'd4; cfg_start = 1'b1;
    cycle();
    host_valid = 1'b0; cfg_start = 1'b0;
    check("restart_drop_ena", bram_ena, 4'h0);
    check("restart_busy", busy, 1'b1);

    // reset in the middle of a load
    wr(0, 0, 32'h22);
    host_valid = 1'b1; host_addra = 20'd4; rst_n = 1'b0;
    cycle();
    host_valid = 1'b0; rst_n = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_ena", bram_ena, 4'h0);

    // randomized episodes
    for (int ep = 0; ep < 40; ep++) begin
      arm(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)),
          ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)),
          ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)),
          ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)));
      for (int k = 0; k < 50; k++) begin
        r = int'($urandom_range(0, 99));
        if (r < 2) begin
          for (int c = 0; c < NUM_CH; c++)
            cfg_exp_cnt[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 5));
          cfg_start = 1'b1;
          host_valid = 1'b1;
        end else if (r == 2) begin
          rst_n = 1'b0;
        end else if (r < 70) begin
          ch = int'($urandom_range(0, NUM_CH - 1));
          if ($urandom_range(0, 15) != 0) begin
            for (int t = 0; t < NUM_CH; t++)
              if (m_done(ch)) ch = (ch + 1) % NUM_CH;
          end
          lim  = (m_exp[ch] > 0) ? m_exp[ch] - 1 : 0;
          word = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, lim));
          host_valid  = 1'b1;
          host_ch_sel = CH_W'(ch);
          host_addra  = (ADDR_W+2)'(word * 4 + (($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 3)) : 0));
          host_din    = $urandom;
        end
        cycle();
        cfg_start = 1'b0; rst_n = 1'b1; host_valid = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
